// File: rtl/core_defs_pkg.sv
// Shared core constants: load/store funct3 format codes used by the data bus.
package core_defs_pkg;

    localparam logic [2:0] F3_B  = 3'b000;  // LB / SB
    localparam logic [2:0] F3_H  = 3'b001;  // LH / SH
    localparam logic [2:0] F3_W  = 3'b010;  // LW / SW
    localparam logic [2:0] F3_BU = 3'b100;  // LBU
    localparam logic [2:0] F3_HU = 3'b101;  // LHU

endpackage

// File: rtl/mmio_uart_pkg.sv
// Register map, STATUS bit positions and TX state encoding for the MMIO UART.
package mmio_uart_pkg;

    // Word index within the 16-byte window (bus_address[3:2]).
    localparam logic [1:0] REG_TXDATA  = 2'd0;  // offset 0x0
    localparam logic [1:0] REG_STATUS  = 2'd1;  // offset 0x4
    localparam logic [1:0] REG_DIVISOR = 2'd2;  // offset 0x8
    localparam logic [1:0] REG_RSVD    = 2'd3;  // offset 0xC

    // STATUS bit positions.
    localparam int ST_FULL      = 0;
    localparam int ST_EMPTY     = 1;
    localparam int ST_BUSY      = 2;
    localparam int ST_OVERFLOW  = 3;
    localparam int ST_COUNT_LSB = 8;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_t;

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO with first-word fall-through read data.
// Pointers carry an extra wrap bit so full and empty are unambiguous.
module uart_tx_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic [7:0]               push_data,
    input  logic                     pop,
    output logic [7:0]               pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic [7:0]  mem [DEPTH];
    logic        do_push;
    logic        do_pop;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count = wr_ptr - rd_ptr;

    // A pop frees a slot on the same edge, so a push into a full FIFO is
    // still accepted when it coincides with a pop.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    assign pop_data = mem[rd_ptr[AW-1:0]];

    // Pointer update
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage write; contents need no reset because the pointers gate them
    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter on the core data bus.
// Decodes a 16-byte register window, merges/extracts byte lanes, buffers
// written bytes in a FIFO and shifts them out at a programmable bit time.
module mmio_uart_tx
    import mmio_uart_pkg::*;
    import core_defs_pkg::*;
#(
    parameter logic [31:0] BASE_ADDRESS    = 32'h0002_0000,
    parameter int          FIFO_DEPTH      = 8,
    parameter logic [15:0] DEFAULT_DIVISOR = 16'd434
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] bus_address,
    input  logic [31:0] bus_write_data,
    input  logic [2:0]  bus_format,
    input  logic        bus_read_enable,
    input  logic        bus_write_enable,
    output logic [31:0] bus_data_fetched,
    output logic        bus_hit,
    output logic        uart_tx
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    // ---------------------------------------------------------------
    // Bus decode and lane handling
    // ---------------------------------------------------------------
    logic [1:0]  reg_idx;
    logic [1:0]  lane;
    logic [3:0]  be;
    logic [15:0] wdata_lane;
    logic        wr;
    logic        push;
    logic        ovf_clear;

    assign bus_hit = (bus_address[31:4] == BASE_ADDRESS[31:4]);
    assign reg_idx = bus_address[3:2];
    assign lane    = bus_address[1:0];
    assign wr      = bus_hit && bus_write_enable;

    // Store data moved onto its byte lanes; only the low half feeds any register.
    assign wdata_lane = 16'(bus_write_data << {lane, 3'b000});

    // Byte enables for the store format at the addressed lane
    always_comb begin
        be = 4'b0000;
        case (bus_format)
            F3_B:    be = 4'b0001 << lane;
            F3_H:    be = 4'b0011 << lane;
            F3_W:    be = 4'b1111;
            default: be = 4'b0000;
        endcase
    end

    // Only a store that covers lane 0 of TXDATA enqueues a byte.
    assign push      = wr && (reg_idx == REG_TXDATA) && be[0];
    assign ovf_clear = wr && (reg_idx == REG_STATUS) && be[0] && wdata_lane[ST_OVERFLOW];

    // ---------------------------------------------------------------
    // FIFO
    // ---------------------------------------------------------------
    logic [7:0]       fifo_data;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    logic             fifo_pop;

    uart_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (push),
        .push_data (wdata_lane[7:0]),
        .pop       (fifo_pop),
        .pop_data  (fifo_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // ---------------------------------------------------------------
    // Registers
    // ---------------------------------------------------------------
    logic [15:0] divisor;
    logic        overflow;
    tx_state_t   state;
    tx_state_t   state_next;

    // Divisor register, byte-writable through the two low lanes
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            divisor <= DEFAULT_DIVISOR;
        end else if (wr && (reg_idx == REG_DIVISOR)) begin
            if (be[0]) divisor[7:0]  <= wdata_lane[7:0];
            if (be[1]) divisor[15:8] <= wdata_lane[15:8];
        end
    end

    // Sticky overflow: a dropped push sets it; writing 1 to bit 3 clears it
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            overflow <= 1'b0;
        end else if (push && fifo_full && !fifo_pop) begin
            overflow <= 1'b1;
        end else if (ovf_clear) begin
            overflow <= 1'b0;
        end
    end

    // ---------------------------------------------------------------
    // Read path
    // ---------------------------------------------------------------
    logic [31:0] status_word;
    logic [31:0] rd_word;
    logic [31:0] rd_shift;

    // Assemble STATUS and select/extend the addressed register for loads
    always_comb begin
        status_word = '0;
        status_word[ST_FULL]     = fifo_full;
        status_word[ST_EMPTY]    = fifo_empty;
        status_word[ST_BUSY]     = (state != TX_IDLE);
        status_word[ST_OVERFLOW] = overflow;
        status_word[ST_COUNT_LSB +: CNT_W] = fifo_count;

        case (reg_idx)
            REG_STATUS:  rd_word = status_word;
            REG_DIVISOR: rd_word = {16'h0000, divisor};
            default:     rd_word = '0;
        endcase

        rd_shift = rd_word >> {lane, 3'b000};

        bus_data_fetched = '0;
        if (bus_hit && bus_read_enable) begin
            case (bus_format)
                F3_B:    bus_data_fetched = {{24{rd_shift[7]}}, rd_shift[7:0]};
                F3_H:    bus_data_fetched = {{16{rd_shift[15]}}, rd_shift[15:0]};
                F3_W:    bus_data_fetched = rd_shift;
                F3_BU:   bus_data_fetched = {24'h0, rd_shift[7:0]};
                F3_HU:   bus_data_fetched = {16'h0, rd_shift[15:0]};
                default: bus_data_fetched = '0;
            endcase
        end
    end

    // ---------------------------------------------------------------
    // Transmitter
    // ---------------------------------------------------------------
    logic [15:0] div_lat;
    logic [15:0] bit_len;
    logic [15:0] baud_cnt;
    logic [2:0]  bit_idx;
    logic [7:0]  shreg;
    logic        tick;

    // A latched divisor of 0 still produces a one-clock bit.
    assign bit_len = (div_lat == 16'd0) ? 16'd1 : div_lat;
    assign tick    = (baud_cnt == bit_len - 16'd1);

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= TX_IDLE;
        else        state <= state_next;
    end

    // Next-state logic; STOP chains directly into START when data is queued
    always_comb begin
        state_next = state;
        case (state)
            TX_IDLE:  if (!fifo_empty) state_next = TX_START;
            TX_START: if (tick) state_next = TX_DATA;
            TX_DATA:  if (tick && (bit_idx == 3'd7)) state_next = TX_STOP;
            TX_STOP:  if (tick) state_next = fifo_empty ? TX_IDLE : TX_START;
            default:  state_next = TX_IDLE;
        endcase
    end

    // Output decode: line level and the pop/load strobe
    always_comb begin
        uart_tx  = 1'b1;
        fifo_pop = 1'b0;
        case (state)
            TX_IDLE:  fifo_pop = !fifo_empty;
            TX_START: uart_tx  = 1'b0;
            TX_DATA:  uart_tx  = shreg[0];
            TX_STOP:  fifo_pop = tick && !fifo_empty;
            default:  uart_tx  = 1'b1;
        endcase
    end

    // Frame datapath: load on pop, count clocks per bit, shift LSB first
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            div_lat  <= DEFAULT_DIVISOR;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
        end else if (fifo_pop) begin
            shreg    <= fifo_data;
            div_lat  <= divisor;
            baud_cnt <= '0;
            bit_idx  <= '0;
        end else if (state != TX_IDLE) begin
            if (tick) begin
                baud_cnt <= '0;
                if (state == TX_DATA) begin
                    shreg   <= {1'b0, shreg[7:1]};
                    bit_idx <= bit_idx + 3'd1;
                end
            end else begin
                baud_cnt <= baud_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx: register access, lane handling,
// FIFO/overflow behaviour and serial framing with hand-computed values.
module tb_mmio_uart_tx;
    import core_defs_pkg::*;

    localparam logic [31:0] BASE = 32'h0002_0000;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] bus_address = '0;
    logic [31:0] bus_write_data = '0;
    logic [2:0]  bus_format = '0;
    logic        bus_read_enable = 1'b0;
    logic        bus_write_enable = 1'b0;
    logic [31:0] bus_data_fetched;
    logic        bus_hit;
    logic        uart_tx;

    int n_cmp = 0;
    int n_bad = 0;

    mmio_uart_tx dut (
        .clock            (clock),
        .reset            (reset),
        .bus_address      (bus_address),
        .bus_write_data   (bus_write_data),
        .bus_format       (bus_format),
        .bus_read_enable  (bus_read_enable),
        .bus_write_enable (bus_write_enable),
        .bus_data_fetched (bus_data_fetched),
        .bus_hit          (bus_hit),
        .uart_tx          (uart_tx)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
        end
    endtask

    // Store lands on the next rising edge; returns 1 time unit after it.
    task automatic store(input logic [3:0] off, input logic [31:0] data, input logic [2:0] fmt);
        @(negedge clock);
        bus_address      = BASE + 32'(off);
        bus_write_data   = data;
        bus_format       = fmt;
        bus_write_enable = 1'b1;
        @(posedge clock);
        #1;
        bus_write_enable = 1'b0;
    endtask

    task automatic load(input logic [31:0] addr, input logic [2:0] fmt,
                        output logic [31:0] data, output logic hit);
        @(negedge clock);
        bus_address     = addr;
        bus_format      = fmt;
        bus_read_enable = 1'b1;
        #1;
        data = bus_data_fetched;
        hit  = bus_hit;
        bus_read_enable = 1'b0;
    endtask

    task automatic chk_load(input string tag, input logic [31:0] addr,
                            input logic [2:0] fmt, input logic [31:0] exp);
        logic [31:0] d;
        logic        h;
        load(addr, fmt, d, h);
        chk(tag, d, exp);
    endtask

    function automatic logic [9:0] frame(input logic [7:0] b);
        return {1'b1, b, 1'b0};
    endfunction

    // Sample the line once per clock; bits[k] is the k-th bit on the wire.
    task automatic watch(input string tag, input logic [19:0] bits, input int nbits,
                         input int div, input int probe_at, input logic [31:0] probe_exp);
        for (int c = 0; c < nbits * div; c++) begin
            chk($sformatf("%s[%0d]", tag, c), {31'd0, uart_tx}, {31'd0, bits[c / div]});
            if (c == probe_at) chk_load({tag, "_status"}, BASE + 32'h4, F3_W, probe_exp);
            @(posedge clock);
            #1;
        end
    endtask

    initial begin
        logic [31:0] d;
        logic        h;

        // Reset
        repeat (3) @(negedge clock);
        chk("tx_in_reset", {31'd0, uart_tx}, 32'd1);
        reset = 1'b1;
        chk_load("rst_status", BASE + 32'h4, F3_W, 32'h0000_0002);
        chk_load("rst_divisor", BASE + 32'h8, F3_W, 32'd434);
        chk("rst_tx", {31'd0, uart_tx}, 32'd1);
        load(BASE + 32'h4, F3_W, d, h);
        chk("hit_window", {31'd0, h}, 32'd1);

        // Single frame 0x55 at divisor 4
        store(4'h8, 32'd4, F3_W);
        store(4'h0, 32'h0000_0055, F3_W);
        chk("tx_before_pop", {31'd0, uart_tx}, 32'd1);
        @(posedge clock);
        #1;
        watch("f55", {10'h0, frame(8'h55)}, 10, 4, 20, 32'h0000_0006);
        chk_load("f55_done", BASE + 32'h4, F3_W, 32'h0000_0002);

        // Divisor lane handling and read decode
        store(4'h8, 32'h0000_1234, F3_H);
        chk_load("lb_08", BASE + 32'h8, F3_B, 32'h0000_0034);
        chk_load("lbu_08", BASE + 32'h8, F3_BU, 32'h0000_0034);
        chk_load("lhu_08", BASE + 32'h8, F3_HU, 32'h0000_1234);
        store(4'h9, 32'h0000_00FF, F3_B);
        chk_load("lh_08", BASE + 32'h8, F3_H, 32'hFFFF_FF34);
        chk_load("lhu_08b", BASE + 32'h8, F3_HU, 32'h0000_FF34);
        chk_load("lb_09", BASE + 32'h9, F3_B, 32'hFFFF_FFFF);
        chk_load("lw_08", BASE + 32'h8, F3_W, 32'h0000_FF34);
        chk_load("lh_0a", BASE + 32'hA, F3_H, 32'h0000_0000);
        chk_load("lw_0c", BASE + 32'hC, F3_W, 32'h0000_0000);
        chk_load("lw_txdata", BASE, F3_W, 32'h0000_0000);
        load(32'h0003_0008, F3_W, d, h);
        chk("unmapped_data", d, 32'h0);
        chk("unmapped_hit", {31'd0, h}, 32'd0);
        @(negedge clock);
        bus_address = BASE + 32'h8;
        bus_format  = F3_W;
        #1;
        chk("no_read_enable", bus_data_fetched, 32'h0);

        // Byte store to lane 1 of TXDATA must not enqueue
        store(4'h1, 32'h0000_0077, F3_B);
        chk_load("sb_lane1_status", BASE + 32'h4, F3_W, 32'h0000_0002);
        chk("sb_lane1_tx", {31'd0, uart_tx}, 32'd1);

        // Back-to-back frames at divisor 3, zero idle clocks between them
        store(4'h8, 32'd3, F3_W);
        store(4'h0, 32'h0000_00A5, F3_B);
        store(4'h0, 32'h0000_003C, F3_B);
        watch("b2b", {frame(8'h3C), frame(8'hA5)}, 20, 3, 35, 32'h0000_0006);
        chk_load("b2b_done", BASE + 32'h4, F3_W, 32'h0000_0002);

        // Fill, overflow and overflow clear at divisor 1000
        store(4'h8, 32'd1000, F3_W);
        store(4'h0, 32'h0000_0000, F3_B);
        repeat (2) @(posedge clock);
        for (int i = 1; i <= 8; i++) store(4'h0, 32'(i), F3_B);
        chk_load("full_status", BASE + 32'h4, F3_W, 32'h0000_0805);
        store(4'h0, 32'h0000_0009, F3_B);
        chk_load("ovf_status", BASE + 32'h4, F3_W, 32'h0000_080D);
        store(4'h4, 32'h0000_0007, F3_W);
        chk_load("ovf_keep", BASE + 32'h4, F3_W, 32'h0000_080D);
        store(4'h4, 32'h0000_0008, F3_W);
        chk_load("ovf_clear", BASE + 32'h4, F3_W, 32'h0000_0805);

        // Reset in the middle of DATA (first byte is 0x00, so the line is low)
        repeat (1200) @(posedge clock);
        #1;
        chk("mid_data_low", {31'd0, uart_tx}, 32'd0);
        reset = 1'b0;
        #1;
        chk("reset_line_high", {31'd0, uart_tx}, 32'd1);
        repeat (3) @(negedge clock);
        reset = 1'b1;
        chk_load("post_rst_status", BASE + 32'h4, F3_W, 32'h0000_0002);
        chk_load("post_rst_divisor", BASE + 32'h8, F3_W, 32'd434);
        repeat (5) @(posedge clock);
        #1;
        chk("post_rst_idle", {31'd0, uart_tx}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
